// File: rtl/cmp_flag_resolver_if.sv
// rtl/cmp_flag_resolver_if.sv - request/result handshake bundle for cmp_flag_resolver
interface cmp_flag_resolver_if #(
  parameter int TAG_W = 4
);
  logic             iValid;
  logic             oReady;
  logic [2:0]       iFlags;
  logic [2:0]       iCond;
  logic [TAG_W-1:0] iTag;
  logic             oValid;
  logic             iReady;
  logic             oTaken;
  logic             oErr;
  logic [TAG_W-1:0] oTag;

  modport slave (
    input  iValid, iFlags, iCond, iTag, iReady,
    output oReady, oValid, oTaken, oErr, oTag
  );

  modport master (
    output iValid, iFlags, iCond, iTag, iReady,
    input  oReady, oValid, oTaken, oErr, oTag
  );
endinterface

// File: rtl/cmp_flag_resolver.sv
// rtl/cmp_flag_resolver.sv - resolves condition codes against {lt,eq,gt} flags through a 2-entry skid buffer
// Optional taken/error statistics counters enabled by CMP_FLAG_STATS_EN.
module cmp_flag_resolver #(
  parameter int TAG_W = 4
`ifdef CMP_FLAG_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic iClk,
  input  logic iRstN,
  cmp_flag_resolver_if.slave io
`ifdef CMP_FLAG_STATS_EN
  , output logic [CNT_W-1:0] oTakenCnt
  , output logic [CNT_W-1:0] oErrCnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_valid;
  logic             r_ready;
  logic             r_head_taken;
  logic             r_head_err;
  logic [TAG_W-1:0] r_head_tag;
  logic             r_tail_taken;
  logic             r_tail_err;
  logic [TAG_W-1:0] r_tail_tag;

  logic w_accept;
  logic w_pop;
  logic w_gt;
  logic w_eq;
  logic w_lt;
  logic w_err;
  logic w_cond_true;
  logic w_taken;

  assign w_gt     = io.iFlags[0];
  assign w_eq     = io.iFlags[1];
  assign w_lt     = io.iFlags[2];
  assign w_accept = io.iValid & r_ready;
  assign w_pop    = r_valid & io.iReady;
  assign w_err    = (io.iFlags != 3'b001) && (io.iFlags != 3'b010) && (io.iFlags != 3'b100);

  always_comb begin
    w_cond_true = 1'b0;
    case (io.iCond)
      3'd0:    w_cond_true = w_eq;
      3'd1:    w_cond_true = !w_eq;
      3'd2:    w_cond_true = w_lt;
      3'd3:    w_cond_true = w_gt | w_eq;
      3'd4:    w_cond_true = w_gt;
      3'd5:    w_cond_true = w_lt | w_eq;
      3'd6:    w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  // A malformed flag vector overrides every condition, ALWAYS included.
  assign w_taken = !w_err && w_cond_true;

  // Head entry drives the outputs directly, so they only move on a pop or a fill from empty.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state      <= S_EMPTY;
      r_valid      <= 1'b0;
      r_ready      <= 1'b1;
      r_head_taken <= 1'b0;
      r_head_err   <= 1'b0;
      r_head_tag   <= '0;
      r_tail_taken <= 1'b0;
      r_tail_err   <= 1'b0;
      r_tail_tag   <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_head_taken <= w_taken;
            r_head_err   <= w_err;
            r_head_tag   <= io.iTag;
            r_valid      <= 1'b1;
            r_state      <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && !w_pop) begin
            r_tail_taken <= w_taken;
            r_tail_err   <= w_err;
            r_tail_tag   <= io.iTag;
            r_ready      <= 1'b0;
            r_state      <= S_TWO;
          end else if (w_pop && !w_accept) begin
            r_valid <= 1'b0;
            r_state <= S_EMPTY;
          end else if (w_accept && w_pop) begin
            r_head_taken <= w_taken;
            r_head_err   <= w_err;
            r_head_tag   <= io.iTag;
          end
        end
        S_TWO: begin
          if (w_pop) begin
            r_head_taken <= r_tail_taken;
            r_head_err   <= r_tail_err;
            r_head_tag   <= r_tail_tag;
            r_ready      <= 1'b1;
            r_state      <= S_ONE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

  assign io.oValid = r_valid;
  assign io.oReady = r_ready;
  assign io.oTaken = r_head_taken;
  assign io.oErr   = r_head_err;
  assign io.oTag   = r_head_tag;

`ifdef CMP_FLAG_STATS_EN
  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  // Saturating counters sampled on the delivered (popped) head entry.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_taken_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (w_pop) begin
      if (r_head_taken && (r_taken_cnt != {CNT_W{1'b1}})) begin
        r_taken_cnt <= r_taken_cnt + 1'b1;
      end
      if (r_head_err && (r_err_cnt != {CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign oTakenCnt = r_taken_cnt;
  assign oErrCnt   = r_err_cnt;
`endif

endmodule

// File: tb/tb_cmp_flag_resolver.sv
// tb/tb_cmp_flag_resolver.sv - directed self-checking bench for cmp_flag_resolver
module tb_cmp_flag_resolver;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  cmp_flag_resolver_if #(.TAG_W(4)) io ();

`ifdef CMP_FLAG_STATS_EN
  logic [3:0] taken_cnt;
  logic [3:0] err_cnt;
`endif

  cmp_flag_resolver #(
    .TAG_W(4)
`ifdef CMP_FLAG_STATS_EN
    , .CNT_W(4)
`endif
  ) u_dut (
    .iClk (clk),
    .iRstN(rst_n),
    .io   (io.slave)
`ifdef CMP_FLAG_STATS_EN
    , .oTakenCnt(taken_cnt)
    , .oErrCnt  (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    io.iValid = 1'b0;
    io.iFlags = 3'b000;
    io.iCond  = 3'd0;
    io.iTag   = 4'h0;
    io.iReady = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({io.oValid, io.oReady, io.oTaken, io.oErr, io.oTag} !== {1'b0, 1'b1, 1'b0, 1'b0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b r=%b t=%b e=%b tag=%h, want v=0 r=1 t=0 e=0 tag=0",
               io.oValid, io.oReady, io.oTaken, io.oErr, io.oTag);
    end
`ifdef CMP_FLAG_STATS_EN
    n_tests++;
    if ({taken_cnt, err_cnt} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_cnt: got taken=%0d err=%0d, want 0 0", taken_cnt, err_cnt);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    // fill both entries with iReady low, then reset between clock edges
    io.iReady = 1'b0;
    io.iValid = 1'b1; io.iFlags = 3'b010; io.iCond = 3'd6; io.iTag = 4'h5;
    @(negedge clk);
    io.iTag = 4'h6;
    @(negedge clk);
    io.iValid = 1'b0;
    n_tests++;
    if ({io.oValid, io.oReady, io.oTag} !== {1'b1, 1'b0, 4'h5}) begin
      n_fail++;
      $display("FAIL reset_prefill: got v=%b r=%b tag=%h, want v=1 r=0 tag=5", io.oValid, io.oReady, io.oTag);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({io.oValid, io.oReady, io.oTag} !== {1'b0, 1'b1, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_async: got v=%b r=%b tag=%h, want v=0 r=1 tag=0", io.oValid, io.oReady, io.oTag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    io.iReady = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (io.oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard: got oValid=%b, want 0", io.oValid);
    end
  endtask

  task automatic test_truth_table();
    logic [2:0] exp_tab [8];
    logic [2:0] fl;
    logic [3:0] tg;
    // bit i of exp_tab[cond] is the result for flags = 1<<i (gt, eq, lt)
    exp_tab[0] = 3'b010; exp_tab[1] = 3'b101; exp_tab[2] = 3'b100; exp_tab[3] = 3'b011;
    exp_tab[4] = 3'b001; exp_tab[5] = 3'b110; exp_tab[6] = 3'b111; exp_tab[7] = 3'b000;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 3; i++) begin
        fl = 3'b001 << i;
        tg = 4'(c * 3 + i);
        @(negedge clk);
        io.iValid = 1'b1; io.iFlags = fl; io.iCond = 3'(c); io.iTag = tg; io.iReady = 1'b1;
        @(negedge clk);
        io.iValid = 1'b0;
        n_tests++;
        if ({io.oValid, io.oErr, io.oTaken, io.oTag} !== {1'b1, 1'b0, exp_tab[c][i], tg}) begin
          n_fail++;
          $display("FAIL truth cond=%0d flags=%b: got v=%b e=%b t=%b tag=%h, want v=1 e=0 t=%b tag=%h",
                   c, fl, io.oValid, io.oErr, io.oTaken, io.oTag, exp_tab[c][i], tg);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_illegal_flags();
    logic [2:0] bad [5];
    bad[0] = 3'b000; bad[1] = 3'b011; bad[2] = 3'b111; bad[3] = 3'b110; bad[4] = 3'b101;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      io.iValid = 1'b1; io.iFlags = bad[i]; io.iCond = 3'd6; io.iTag = 4'(9 + i); io.iReady = 1'b1;
      @(negedge clk);
      io.iValid = 1'b0;
      n_tests++;
      if ({io.oValid, io.oErr, io.oTaken, io.oTag} !== {1'b1, 1'b1, 1'b0, 4'(9 + i)}) begin
        n_fail++;
        $display("FAIL illegal flags=%b: got v=%b e=%b t=%b tag=%h, want v=1 e=1 t=0 tag=%h",
                 bad[i], io.oValid, io.oErr, io.oTaken, io.oTag, 4'(9 + i));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [3:0] got [$];
    logic       sent;
    int         cyc;
    @(negedge clk);
    io.iReady = 1'b0;
    io.iValid = 1'b1; io.iFlags = 3'b100; io.iCond = 3'd2; io.iTag = 4'h1;
    @(negedge clk);
    n_tests++;
    if (io.oReady !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_one: got oReady=%b, want 1", io.oReady);
    end
    io.iTag = 4'h2;
    @(negedge clk);
    io.iTag = 4'h3;
    n_tests++;
    if ({io.oReady, io.oValid, io.oTag} !== {1'b0, 1'b1, 4'h1}) begin
      n_fail++;
      $display("FAIL bp_full: got r=%b v=%b tag=%h, want r=0 v=1 tag=1", io.oReady, io.oValid, io.oTag);
    end
    @(negedge clk);
    n_tests++;
    if ({io.oReady, io.oTaken, io.oTag} !== {1'b0, 1'b1, 4'h1}) begin
      n_fail++;
      $display("FAIL bp_hold: got r=%b t=%b tag=%h, want r=0 t=1 tag=1", io.oReady, io.oTaken, io.oTag);
    end
    sent = 1'b0;
    cyc  = 0;
    io.iReady = 1'b1;
    while (got.size() < 3 && cyc < 20) begin
      if (sent) io.iValid = 1'b0;
      if (io.oValid) got.push_back(io.oTag);
      if (io.iValid && io.oReady) sent = 1'b1;
      @(negedge clk);
      cyc++;
    end
    io.iValid = 1'b0;
    n_tests++;
    if (got.size() != 3) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results, want 3", got.size());
    end else begin
      n_tests++;
      if ({got[0], got[1], got[2]} !== {4'h1, 4'h2, 4'h3}) begin
        n_fail++;
        $display("FAIL bp_order: got %h,%h,%h, want 1,2,3", got[0], got[1], got[2]);
      end
    end
    @(negedge clk);
    n_tests++;
    if (io.oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got oValid=%b, want 0", io.oValid);
    end
  endtask

  task automatic test_streaming();
    @(negedge clk);
    for (int k = 0; k <= 100; k++) begin
      if (k > 0) begin
        n_tests++;
        if ({io.oValid, io.oTaken, io.oErr, io.oReady, io.oTag} !== {1'b1, 1'b1, 1'b0, 1'b1, 4'(k - 1)}) begin
          n_fail++;
          $display("FAIL stream k=%0d: got v=%b t=%b e=%b r=%b tag=%h, want v=1 t=1 e=0 r=1 tag=%h",
                   k, io.oValid, io.oTaken, io.oErr, io.oReady, io.oTag, 4'(k - 1));
        end
      end
      if (k < 100) begin
        io.iValid = 1'b1; io.iFlags = 3'b010; io.iCond = 3'd6; io.iTag = 4'(k); io.iReady = 1'b1;
      end else begin
        io.iValid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

`ifdef CMP_FLAG_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      if (k == 4) begin
        n_tests++;
        if (taken_cnt !== 4'd3) begin
          n_fail++;
          $display("FAIL stats_partial: got oTakenCnt=%0d, want 3", taken_cnt);
        end
      end
      io.iValid = 1'b1; io.iFlags = 3'b100; io.iCond = 3'd2; io.iTag = 4'(k); io.iReady = 1'b1;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      io.iValid = 1'b1; io.iFlags = 3'b000; io.iCond = 3'd6; io.iTag = 4'(k);
      @(negedge clk);
    end
    io.iValid = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (taken_cnt !== 4'd15) begin
      n_fail++;
      $display("FAIL stats_taken_sat: got oTakenCnt=%0d, want 15", taken_cnt);
    end
    n_tests++;
    if (err_cnt !== 4'd3) begin
      n_fail++;
      $display("FAIL stats_err: got oErrCnt=%0d, want 3", err_cnt);
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_truth_table();
    test_illegal_flags();
    test_backpressure();
    test_streaming();
`ifdef CMP_FLAG_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
